// File: rtl/adder_tree_sched.sv
// Shares one adder_tree among NUM_REQ requesters: locks a grant per job, forwards beats, accumulates tree sums.
// Define ADDER_TREE_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
//
// state | meaning
// IDLE  | no job; arbitrate among valid requesters
// ISSUE | owner streams beats to the tree
// DRAIN | all beats issued; wait for outstanding tree sums
// DONE  | result presented until res_ready_i
module adder_tree_sched #(
  parameter int NUM_REQ  = 4,
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int SUM_W    = ELEM_W + $clog2(NUM_ELEM),
  parameter int LEN_W    = 8,
  parameter int ACC_W    = SUM_W + LEN_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  input  logic [NUM_REQ*NUM_ELEM*ELEM_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                tree_valid_o,
  output logic [NUM_ELEM*ELEM_W-1:0]          tree_data_o,
  input  logic                                tree_sum_valid_i,
  input  logic [SUM_W-1:0]                    tree_sum_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [ACC_W-1:0]                    res_data_o,
  output logic [$clog2(NUM_REQ)-1:0]          res_id_o,
  output logic [LEN_W-1:0]                    res_beats_o,
  output logic                                err_o
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = NUM_ELEM * ELEM_W;
  localparam logic [LEN_W-1:0] LAST_CNT = {{(LEN_W-1){1'b1}}, 1'b0};
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  returned;
  logic [ACC_W-1:0]  acc;

  logic [BEAT_W-1:0] beat [NUM_REQ];
  logic              hs;
  logic              beat_last;
  logic              sum_ok;
  logic              sum_bad;
  logic [ACC_W-1:0]  acc_nxt;
  logic [LEN_W-1:0]  ret_nxt;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
    assign beat[g] = req_data_i[g*BEAT_W +: BEAT_W];
  end

`ifdef ADDER_TREE_SCHED_RR_EN
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);
  logic [ID_W-1:0] rr_ptr;

  // Scan from the pointer downwards in offset so the closest valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      logic [ID_W:0] pos;
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (req_valid_i[pos[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = pos[ID_W-1:0];
      end
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`endif

  // A sum is only accepted while at least one beat is outstanding.
  always_comb begin
    hs        = req_valid_i[owner] & req_ready_o[owner];
    beat_last = req_last_i[owner] | (issued == LAST_CNT);
    sum_ok    = tree_sum_valid_i & ((state == ISSUE) | (state == DRAIN)) & (returned != issued);
    sum_bad   = tree_sum_valid_i & ~sum_ok;
    acc_nxt   = acc;
    ret_nxt   = returned;
    if (sum_ok) begin
      acc_nxt = acc + {{LEN_W{tree_sum_i[SUM_W-1]}}, tree_sum_i};
      ret_nxt = returned + {{(LEN_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      issued       <= '0;
      returned     <= '0;
      acc          <= '0;
      req_ready_o  <= '0;
      tree_valid_o <= 1'b0;
      tree_data_o  <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      res_id_o     <= '0;
      res_beats_o  <= '0;
      err_o        <= 1'b0;
`ifdef ADDER_TREE_SCHED_RR_EN
      rr_ptr       <= '0;
`endif
    end else begin
      tree_valid_o <= 1'b0;
      if (sum_ok) begin
        acc      <= acc_nxt;
        returned <= ret_nxt;
      end
      if (sum_bad) err_o <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_any) begin
            owner       <= grant_id;
            acc         <= '0;
            issued      <= '0;
            returned    <= '0;
            req_ready_o <= ONE_HOT0 << grant_id;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            tree_data_o  <= beat[owner];
            tree_valid_o <= 1'b1;
            issued       <= issued + {{(LEN_W-1){1'b0}}, 1'b1};
            if (beat_last) begin
              req_ready_o <= '0;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Uses the post-accumulate count so the final sum completes the job in the same cycle.
          if (ret_nxt == issued) begin
            res_valid_o <= 1'b1;
            res_data_o  <= acc_nxt;
            res_id_o    <= owner;
            res_beats_o <= issued;
            state       <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= IDLE;
`ifdef ADDER_TREE_SCHED_RR_EN
            rr_ptr      <= (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
